mem_wb_skid_stage: RTL and testbench
====================================

MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of the ALU-result and memory-data fields.
REQ-002 The block SHALL have parameter RD_W, default 5: width of the destination-register index.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  the upstream MEM stage presents a valid instruction.
REQ-006 in_ready  out  1  the stage accepts input this cycle; driven from a register.
REQ-007 alu_result_in  in  DATA_W; mem_data_in  in  DATA_W; rd_in  in  RD_W; reg_write_in  in  1; mem_to_reg_in  in  1: payload fields.
REQ-008 flush  in  1  discards all held entries.
REQ-009 out_valid  out  1  the output payload is valid.
REQ-010 out_ready  in  1  the downstream WB stage consumes the output this cycle.
REQ-011 alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out  out: registered payload, with widths matching the inputs.
REQ-012 occupancy  out  2  number of held entries (0..2).

Function
REQ-013 The stage SHALL hold two entries: a main entry that drives the outputs and a skid entry.
REQ-014 The stage SHALL have three states: EMPTY (occupancy 0), ONE (main entry only) and FULL (main and skid).
REQ-015 Accept SHALL mean in_valid && in_ready; consume SHALL mean out_valid && out_ready.
REQ-016 EMPTY: on accept, the stage SHALL load the main entry and move to ONE.
REQ-017 ONE, accept and consume together: the stage SHALL replace the main entry and stay in ONE.
REQ-018 ONE, accept only: the stage SHALL load the skid entry and move to FULL.
REQ-019 ONE, consume only: the stage SHALL move to EMPTY.
REQ-020 FULL, consume: the stage SHALL move the skid entry to the main entry and move to ONE.
REQ-021 in_ready SHALL be 0 in FULL and 1 otherwise, so that an accept never occurs in FULL.
REQ-022 Latency SHALL be one cycle from accept to out_valid when the stage is EMPTY; sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-023 Order SHALL be preserved; no entry SHALL be duplicated or dropped except by flush.
REQ-024 On capture, the stored reg_write SHALL be reg_write_in && (rd_in != 0), suppressing writes to x0.
REQ-025 reg_write_out SHALL be 0 whenever out_valid=0.
REQ-026 A payload held with out_valid=1 and out_ready=0 SHALL remain stable.
REQ-027 flush=1 SHALL move the stage to EMPTY at the next edge and set in_ready to 1.
REQ-028 flush SHALL take priority over a simultaneous accept (the input is dropped) and over a simultaneous consume.
REQ-029 occupancy SHALL equal the state count after every edge.

Reset
REQ-030 While rst=1 at an edge, the stage SHALL enter EMPTY.
REQ-031 Reset values SHALL be: out_valid=0, in_ready=1, occupancy=0, every payload output 0.
REQ-032 rst SHALL override flush, accept and consume.
REQ-033 Reset mid-operation SHALL discard all held entries.

Configuration
REQ-034 With macro MEM_WB_WB_MUX_EN defined, the block SHALL add output wb_data_out (DATA_W wide), equal to mem_data_out when mem_to_reg_out=1 and to alu_result_out otherwise.
REQ-035 wb_data_out SHALL be combinational from the registered outputs and SHALL be 0 after reset.
REQ-036 Without MEM_WB_WB_MUX_EN, wb_data_out SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Reset then pass-through: after rst, in_valid=1, alu=AAAABBBB, mem=11112222, rd=3, rw=1, m2r=0, out_ready=1 -> next cycle out_valid=1, alu_result_out=AAAABBBB, rd_out=3, reg_write_out=1, occupancy=1.
REQ-038 Backpressure: out_ready=0, accept CCCCDDDD then 12345678 -> occupancy=2, in_ready=0, output holds CCCCDDDD; then out_ready=1 -> CCCCDDDD, then 12345678, in order.
REQ-039 x0 suppression: rd_in=0, reg_write_in=1 -> rd_out=0, reg_write_out=0.
REQ-040 Flush while FULL together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, new input dropped.
REQ-041 Reset mid-operation: rst=1 while FULL -> next cycle all outputs 0, in_ready=1; with MEM_WB_WB_MUX_EN, m2r=1, mem=33334444 -> wb_data_out=33334444.

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage
//   Two-entry skid buffer between the MEM and WB pipeline stages. The main
//   entry drives the outputs. The skid entry catches one extra instruction
//   when WB stalls. Because in_ready comes straight from a flop, the upstream
//   ready path stays short.
//
// Optional feature (macro MEM_WB_WB_MUX_EN):
//   adds wb_data_out, which selects between mem_data_out and alu_result_out
//   using mem_to_reg_out.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            upstream handshake (in_ready registered)
//   alu_result_in, mem_data_in,
//   rd_in, reg_write_in,
//   mem_to_reg_in                  incoming payload
//   flush                          drop every held entry
//   out_valid / out_ready          downstream handshake
//   alu_result_out, mem_data_out,
//   rd_out, reg_write_out,
//   mem_to_reg_out                 registered payload of the main entry
//   occupancy                      held entries, 0..2
//   wb_data_out                    write-back mux output (MEM_WB_WB_MUX_EN only)
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | nothing held, outputs invalid
// ST_ONE   | main entry valid, skid entry free
// ST_FULL  | main and skid entries valid, in_ready low

module mem_wb_skid_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic [RD_W-1:0]   rd_in,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [RD_W-1:0]   rd_out,
   output logic              reg_write_out,
   output logic              mem_to_reg_out,
   output logic [1:0]        occupancy
`ifdef MEM_WB_WB_MUX_EN
   ,
   output logic [DATA_W-1:0] wb_data_out
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mem;
      logic [RD_W-1:0]   rd;
      logic              rw;
      logic              m2r;
   } entry_t;

   // The encoding equals the entry count, so occupancy is the state register.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;

   entry_t in_entry;
   logic   accept;
   logic   consume;

   always_comb begin
      in_entry     = '0;
      in_entry.alu = alu_result_in;
      in_entry.mem = mem_data_in;
      in_entry.rd  = rd_in;
      // Writes to x0 are dropped here, so WB never needs to test for them.
      in_entry.rw  = reg_write_in && (rd_in != '0);
      in_entry.m2r = mem_to_reg_in;
   end

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid && in_ready_q;
   assign consume   = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               main_d = in_entry;
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = ST_FULL;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (consume) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush beats accept and consume. Payload flops are left alone because
      // out_valid and the reg_write gate already hide them.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end

      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign occupancy      = state_q;
   assign alu_result_out = main_q.alu;
   assign mem_data_out   = main_q.mem;
   assign rd_out         = main_q.rd;
   assign reg_write_out  = main_q.rw && out_valid;
   assign mem_to_reg_out = main_q.m2r;

`ifdef MEM_WB_WB_MUX_EN
   assign wb_data_out = main_q.m2r ? main_q.mem : main_q.alu;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Testbench for mem_wb_skid_stage.
//   The reference is a plain queue of held instructions, at most two deep.
//   Accepted instructions are pushed on the clock edge. A monitor on the
//   falling edge compares the DUT outputs against the queue head. The monitor
//   pops the head whenever the DUT presents an instruction and WB takes it.

module tb_mem_wb_skid_stage;
   localparam int DATA_W = 32;
   localparam int RD_W   = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_result_in;
   logic [DATA_W-1:0] mem_data_in;
   logic [RD_W-1:0]   rd_in;
   logic              reg_write_in;
   logic              mem_to_reg_in;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_result_out;
   logic [DATA_W-1:0] mem_data_out;
   logic [RD_W-1:0]   rd_out;
   logic              reg_write_out;
   logic              mem_to_reg_out;
   logic [1:0]        occupancy;
`ifdef MEM_WB_WB_MUX_EN
   logic [DATA_W-1:0] wb_data_out;
`endif

   mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .alu_result_in  (alu_result_in),
      .mem_data_in    (mem_data_in),
      .rd_in          (rd_in),
      .reg_write_in   (reg_write_in),
      .mem_to_reg_in  (mem_to_reg_in),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .alu_result_out (alu_result_out),
      .mem_data_out   (mem_data_out),
      .rd_out         (rd_out),
      .reg_write_out  (reg_write_out),
      .mem_to_reg_out (mem_to_reg_out),
      .occupancy      (occupancy)
`ifdef MEM_WB_WB_MUX_EN
      ,
      .wb_data_out    (wb_data_out)
`endif
   );

   typedef struct {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] mem;
      logic [RD_W-1:0]   rd;
      logic              rw;
      logic              m2r;
   } ent_t;

   ent_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   rst_seen = 1'b0;
   bit   exp_in_ready = 1'b1;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: capture side.
   always @(posedge clk) begin
      ent_t e;
      if (rst) begin
         q.delete();
         rst_seen = 1'b1;
      end else begin
         rst_seen = 1'b0;
         if (flush) begin
            q.delete();
         end else if (in_valid && exp_in_ready) begin
            e.alu = alu_result_in;
            e.mem = mem_data_in;
            e.rd  = rd_in;
            e.rw  = reg_write_in && (rd_in != 0);
            e.m2r = mem_to_reg_in;
            q.push_back(e);
         end
      end
   end

   // Monitor: compare against the model, then pop on a consume.
   always @(negedge clk) begin
      check("occupancy", 64'(occupancy), 64'(q.size()));
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      exp_in_ready = (q.size() < 2);
      if (rst_seen) begin
         check("rst_alu", 64'(alu_result_out), 64'd0);
         check("rst_mem", 64'(mem_data_out), 64'd0);
         check("rst_rd", 64'(rd_out), 64'd0);
         check("rst_m2r", 64'(mem_to_reg_out), 64'd0);
`ifdef MEM_WB_WB_MUX_EN
         check("rst_wb_data", 64'(wb_data_out), 64'd0);
`endif
      end
      if (!out_valid) begin
         check("rw_gated", 64'(reg_write_out), 64'd0);
      end else if (q.size() != 0) begin
         check("alu_out", 64'(alu_result_out), 64'(q[0].alu));
         check("mem_out", 64'(mem_data_out), 64'(q[0].mem));
         check("rd_out", 64'(rd_out), 64'(q[0].rd));
         check("rw_out", 64'(reg_write_out), 64'(q[0].rw));
         check("m2r_out", 64'(mem_to_reg_out), 64'(q[0].m2r));
`ifdef MEM_WB_WB_MUX_EN
         check("wb_data", 64'(wb_data_out), 64'(q[0].m2r ? q[0].mem : q[0].alu));
`endif
         if (out_ready && !rst && !flush) void'(q.pop_front());
      end
   end

   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] m,
                       input logic [4:0] r, input logic w, input logic mr,
                       input logic ordy, input logic fl, input logic rs);
      in_valid      = v;
      alu_result_in = a;
      mem_data_in   = m;
      rd_in         = r;
      reg_write_in  = w;
      mem_to_reg_in = mr;
      out_ready     = ordy;
      flush         = fl;
      rst           = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Pass-through straight after reset.
      step(1'b1, 32'hAAAABBBB, 32'h11112222, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);

      // Backpressure: fill both entries, hold, then drain in order.
      step(1'b1, 32'hCCCCDDDD, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h12345678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Write to x0 is suppressed.
      step(1'b1, 32'hDEAD0000, 32'hBEEF0000, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1'b1);

      // Flush while full, with a new input that must be dropped.
      step(1'b1, 32'hA1, 32'hB1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hA2, 32'hB2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hA3, 32'hB3, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Reset while full, then a memory-sourced write-back.
      step(1'b1, 32'h55555555, 32'h33334444, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h66666666, 32'h77778888, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(1'b1);
      step(1'b1, 32'h99999999, 32'h33334444, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 9) < 7), $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              1'($urandom), 1'($urandom),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 3),
              ($urandom_range(0, 199) < 2));
      end

      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
